// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   mdu_op_e : RV32M funct3 operation encodings
//   state_e  : control FSM states (IDLE -> CALC -> FIX)
//   MDU_XLEN : default operand/result width
//   ITER_W   : iteration counter width for the default width
package rv32m_pkg;

  localparam int MDU_XLEN = 32;
  localparam int ITER_W   = $clog2(MDU_XLEN);

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute-stage control and the
// multiply/divide unit.
//   start, op, rs1, rs2 : request (sampled only while busy = 0)
//   busy                : operation in progress
//   done, res           : one-cycle completion pulse and its result
// master = requester (control/testbench), slave = mul_div_unit.
interface mul_div_unit_if
  import rv32m_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
);

  logic            start;
  mdu_op_e         op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] res;

  modport master (output start, op, rs1, rs2, input busy, done, res);
  modport slave  (input start, op, rs1, rs2, output busy, done, res);

endinterface

// File: rtl/mdu_iter_datapath.sv
// One-bit-per-cycle iterative datapath shared by multiply and divide.
//   clk, rst : clock, synchronous active-high reset
//   load     : initialise from unsigned magnitudes a_in, b_in
//   step     : perform one iteration
//   is_div   : 1 = restoring shift-subtract, 0 = shift-add
//   hi, lo   : multiply -> {hi,lo} is the 2*XLEN product
//              divide   -> hi is the remainder, lo the quotient
module mdu_iter_datapath #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  // Multiplicand for multiply, divisor for divide.
  logic [XLEN-1:0] m_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier bit (lo[0]) is set; the carry is kept for the shift right.
  // Divide: shift the next dividend bit into the partial remainder and try
  // subtracting the divisor; bit XLEN of the difference is the borrow.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, m_q};
  end

  // NOTE: the datapath registers are cleared by reset so that nothing from
  // an aborted operation can leak into the next one; non-blocking
  // assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      hi  <= '0;
      lo  <= '0;
    end else if (load) begin
      hi  <= '0;
      m_q <= is_div ? b_in : a_in;
      lo  <= is_div ? a_in : b_in;
    end else if (step) begin
      if (is_div) begin
        if (!div_diff[XLEN]) begin
          hi <= div_diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= div_shift[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        hi <= mul_sum[XLEN:1];
        lo <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of mul_div_unit_if (start/op/rs1/rs2 in,
//         busy/done/res out)
// Flow: IDLE accepts start and latches sign flags and magnitudes; CALC runs
// XLEN iterations; FIX applies sign correction, registers res and pulses
// done. Divide-by-zero and signed overflow may skip CALC (EARLY_OUT).
module mul_div_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN      = MDU_XLEN,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_n;
  logic [CNT_W-1:0] cnt_q;
  mdu_op_e         op_q;
  logic            neg_q;
  logic            fast_q;
  logic [XLEN-1:0] fast_res_q;
  logic            done_q;
  logic [XLEN-1:0] res_q;

  logic            accept;
  logic            load, step;
  logic            dp_is_div;
  logic            a_signed, b_signed;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic            fast_hit;
  logic            res_neg_in;
  logic [XLEN-1:0] fast_val;
  logic [XLEN-1:0] dp_hi, dp_lo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] div_raw, res_fix;

  assign accept   = (state_q == IDLE) && bus.start;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.res  = res_q;

  // Operand decode for the request presented in IDLE.
  always_comb begin
    a_signed = (bus.op == MDU_MULH) || (bus.op == MDU_MULHSU) ||
               (bus.op == MDU_DIV)  || (bus.op == MDU_REM);
    b_signed = (bus.op == MDU_MULH) || (bus.op == MDU_DIV) ||
               (bus.op == MDU_REM);
    neg_a    = a_signed && bus.rs1[XLEN-1];
    neg_b    = b_signed && bus.rs2[XLEN-1];
    mag_a    = neg_a ? -bus.rs1 : bus.rs1;
    mag_b    = neg_b ? -bus.rs2 : bus.rs2;
    div_zero = (bus.rs2 == '0);
    div_ovf  = ((bus.op == MDU_DIV) || (bus.op == MDU_REM)) &&
               (bus.rs1 == MOST_NEG) && (bus.rs2 == '1);
    fast_hit = EARLY_OUT && bus.op[2] && (div_zero || div_ovf);

    // A zero divisor yields an all-ones quotient magnitude; it must stay
    // unsigned so DIV x/0 returns -1 when the full iteration is run.
    unique case (bus.op)
      MDU_MULH, MDU_MULHSU: res_neg_in = neg_a ^ neg_b;
      MDU_DIV:              res_neg_in = (neg_a ^ neg_b) && !div_zero;
      MDU_REM:              res_neg_in = neg_a;
      default:              res_neg_in = 1'b0;
    endcase

    // op[1] separates remainder from quotient among the divide ops.
    if (div_zero) fast_val = bus.op[1] ? bus.rs1 : '1;
    else          fast_val = bus.op[1] ? '0 : MOST_NEG;
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_n = fast_hit ? FIX : CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt_q == CNT_W'(XLEN - 1)) state_n = FIX;
      end
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  assign dp_is_div = (state_q == IDLE) ? bus.op[2] : op_q[2];

  mdu_iter_datapath #(.XLEN(XLEN)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .is_div (dp_is_div),
    .a_in   (mag_a),
    .b_in   (mag_b),
    .hi     (dp_hi),
    .lo     (dp_lo)
  );

  // Products are negated across the full double width so the high half
  // picks up the borrow out of the low half.
  always_comb begin
    prod_fix = neg_q ? -{dp_hi, dp_lo} : {dp_hi, dp_lo};
    div_raw  = op_q[1] ? dp_hi : dp_lo;
    if (op_q[2])              res_fix = neg_q ? -div_raw : div_raw;
    else if (op_q == MDU_MUL) res_fix = prod_fix[XLEN-1:0];
    else                      res_fix = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      op_q       <= MDU_MUL;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
      fast_res_q <= '0;
      done_q     <= 1'b0;
      res_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q       <= bus.op;
        neg_q      <= res_neg_in;
        fast_q     <= fast_hit;
        fast_res_q <= fast_val;
        cnt_q      <= '0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == FIX) begin
        res_q  <= fast_q ? fast_res_q : res_fix;
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit beside the combinational ALU in the execute stage.
- Consumes the same rs1/rs2 operand buses the ALU reads.
- Produces a 32-bit result after a multi-cycle operation.
- Asserts busy so the control unit can hold PC and register-file writeback until done.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.
EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow cases finish in the fast path; 0 = they run the full iteration.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1  input  XLEN  operand A / dividend; sampled with start.
rs2  input  XLEN  operand B / divisor; sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; res valid.
res  output  XLEN  result; held from done until the next accepted start.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset:
  - state IDLE; busy=0, done=0, res=0; counter and datapath registers cleared.
  - rst dominates start in the same cycle.
- States:
  - IDLE: start=1 at edge E0 latches op, rs1, rs2, then goes to CALC.
    - For signed ops, latch operand magnitudes and the result-sign flag at E0.
    - MULHSU: only rs1 is signed.
    - DIV: quotient sign = sign(rs1) XOR sign(rs2). REM: remainder sign = sign(rs1).
  - CALC: one iteration per cycle, edges E1..E32, 5-bit counter.
    - Multiply: shift-add over a 64-bit product register.
    - Divide: restoring shift-subtract, 32-bit remainder plus 32-bit quotient.
    - Counter wraps 31 -> 0 on the E32 transition to FIX.
  - FIX: at E33, apply two's-complement sign correction and select the result.
    - MUL selects the low 32 bits; MULH/MULHSU/MULHU the high 32 bits.
    - Quotient or remainder as per op.
    - Register res, pulse done, return to IDLE.
  - done is high in the cycle after E33 (normal latency 34 edges); busy is high from after E0 until E33.
- Fast path (EARLY_OUT=1), taken at E0 → FIX, so done follows E1:
  - rs2=0, DIV/DIVU: res=0xFFFFFFFF.
  - rs2=0, REM/REMU: res=rs1.
  - rs1=0x80000000, rs2=0xFFFFFFFF, DIV: res=0x80000000.
  - Same operands, REM: res=0.
- Protocol:
  - start while busy=1 is ignored; operands are not re-sampled.
  - In the done cycle busy=0, so start is accepted there (back-to-back issue; the next done comes 34 edges later).
  - done is never asserted without a preceding accepted start.
  - res is unchanged in IDLE without start.
- Reset mid-operation: abort, with no done pulse ever produced for the aborted op.
- All arithmetic is unsigned internally, XLEN-bit magnitudes, 2*XLEN product register; no overflow flags.

Decomposition:
- Package rv32m_pkg:
  - op encodings (MDU_MUL ... MDU_REMU);
  - state encoding IDLE/CALC/FIX;
  - helper constant ITER_W = clog2(XLEN).
- One sub-module is natural: mdu_iter_datapath, holding the shift-add / shift-subtract registers and one-step logic, steered by an is_div flag.
- FSM, sign handling, fast path and output registers remain in mul_div_unit.

Test Plan:
1. MUL, rs1=7, rs2=0xFFFFFFFD -> res=0xFFFFFFEB; done exactly one cycle, following E33; busy high 33 cycles.
2. High-half multiplies:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. Divide/remainder:
   - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
   - REM same operands -> 0xFFFFFFFF.
   - DIVU 0xFFFFFFFE / 3 -> 0x55555554.
   - REMU same operands -> 2.
4. Special cases, each with done after E1 (EARLY_OUT=1):
   - DIV 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
   - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
5. Issue and hold:
   - Start pulses at E5 and E20 during a MUL -> the E20 pulse is ignored; result from the E0 operands only.
   - New start in the done cycle -> accepted; second done 34 edges later; res holds the first value until then.
6. rst=1 at E10 of a DIVU -> next cycle busy=0, done=0, res=0; no done in the following 40 cycles.
